// File: rtl/apb_master_if.sv
// Command/response and APB signal bundle between the bridge front-end, the APB initiator and its completers.
interface apb_master_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_addr;
   logic [DATA_WIDTH-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   // Initiator view: takes commands, drives APB, returns responses
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
   );

   // Environment view: command source plus APB completer
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
   );
endinterface

// File: rtl/apb_master.sv
// APB3 initiator: one outstanding command turned into a SETUP/ACCESS transfer,
// with an optional wait-state timeout so a stuck completer cannot hang the bridge.
module apb_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 16
) (
   input logic          pclk,
   input logic          presetn,
   apb_master_if.master bus
);
   // Counter only has to reach TIMEOUT-1; the abort fires on that value with pready low
   localparam int unsigned CNT_W    = (TIMEOUT <= 2) ? 1 : $clog2(TIMEOUT);
   localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

   state_e                state_q, state_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
   logic                  timeout_hit;

   assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_W'(CNT_LAST));

   // Next-state and next-output logic; psel/penable reflect the state being entered
   always_comb begin
      state_d     = state_q;
      psel_d      = 1'b0;
      penable_d   = 1'b0;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      wait_cnt_d  = '0;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               pwrite_d = bus.cmd_write;
               paddr_d  = bus.cmd_addr;
               pwdata_d = bus.cmd_wdata;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            psel_d    = 1'b1;
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (bus.pready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = bus.pslverr;
               rsp_rdata_d = (!pwrite_q && !bus.pslverr) ? bus.prdata : '0;
            end else if (timeout_hit) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
            end else begin
               psel_d    = 1'b1;
               penable_d = 1'b1;
               if (TIMEOUT != 0) wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign bus.cmd_ready = (state_q == IDLE);
   assign bus.psel      = psel_q;
   assign bus.penable   = penable_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.paddr     = paddr_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_apb_master.sv
// Scenario bench for apb_master: a configurable APB completer plus a queue of expected responses.
module tb_apb_master;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   typedef struct {
      logic          err;
      logic [DW-1:0] rdata;
   } rsp_t;

   logic pclk = 1'b0;
   logic presetn;
   int   vectors = 0;
   int   miscompares = 0;
   int   rsp_count = 0;
   rsp_t exp_q[$];

   // Completer behaviour: ready after wait_cfg ACCESS cycles (never if negative)
   int            wait_cfg = 0;
   logic          err_cfg = 1'b0;
   logic [DW-1:0] rdata_cfg = '0;
   int            acc_cnt;

   apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
   );

   always #5 pclk = ~pclk;

   // pslverr is driven high whenever it must be ignored, so only the ready cycle counts
   initial begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = '0;
      acc_cnt     = 0;
      forever begin
         @(negedge pclk);
         if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
            bus.pready = (wait_cfg >= 0 && acc_cnt == wait_cfg);
            acc_cnt++;
         end else begin
            bus.pready = 1'b0;
            acc_cnt    = 0;
         end
         bus.pslverr = (bus.psel === 1'b1) ? (bus.pready ? err_cfg : 1'b1) : 1'b0;
         bus.prdata  = rdata_cfg;
      end
   end

   initial forever begin
      @(negedge pclk);
      if (bus.rsp_valid === 1'b1) rsp_count++;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, required finish before 100000ns");
      $fatal(1);
   end

   function automatic rsp_t pop_exp();
      rsp_t e;
      e.err   = 1'bx;
      e.rdata = 'x;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      return e;
   endfunction

   // Presents a command from a negedge, returns at the negedge after the handshake (cycle N+1)
   task automatic send_cmd(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input int wt, input logic err, input logic [DW-1:0] rd, input logic keep);
      rsp_t e;
      int   n;
      wait_cfg      = wt;
      err_cfg       = err;
      rdata_cfg     = rd;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_wdata = wdata;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 50) begin
         @(negedge pclk);
         n++;
      end
      vectors++;
      if (bus.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL accept: cmd_ready=%b required 1", bus.cmd_ready);
      end
      e.err   = (wt < 0) ? 1'b1 : err;
      e.rdata = (wt < 0 || wr || err) ? '0 : rd;
      exp_q.push_back(e);
      @(posedge pclk);
      @(negedge pclk);
      if (!keep) bus.cmd_valid = 1'b0;
   endtask

   // lat is the cycle index (relative to the handshake edge) at which rsp_valid is seen
   task automatic wait_rsp(input int start, output int lat);
      lat = start;
      while (bus.rsp_valid !== 1'b1 && lat < start + 30) begin
         @(negedge pclk);
         lat++;
      end
   endtask

   task automatic test_reset();
      presetn       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      repeat (2) @(negedge pclk);
      vectors++;
      if ({bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl: psel/penable/pwrite/rsp_valid/rsp_err=%b required 00000",
                  {bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err});
      end
      vectors++;
      if (bus.paddr !== '0 || bus.pwdata !== '0 || bus.rsp_rdata !== '0) begin
         miscompares++;
         $display("FAIL reset_data: paddr=%h pwdata=%h rsp_rdata=%h required 0", bus.paddr, bus.pwdata, bus.rsp_rdata);
      end
      presetn = 1'b1;
      @(negedge pclk);
      vectors++;
      if (bus.cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_ready: cmd_ready=%b required 1", bus.cmd_ready);
      end
   endtask

   task automatic test_write_zero_wait();
      rsp_t e;
      int   lat;
      send_cmd(1'b1, 32'h4, 32'hDEADBEEF, 0, 1'b0, 32'hA5A5A5A5, 1'b0);
      vectors++;
      if ({bus.psel, bus.penable, bus.pwrite} !== 3'b101 || bus.paddr !== 32'h4 || bus.pwdata !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL wr_setup: psel/pen/pwrite=%b paddr=%h pwdata=%h required 101 4 deadbeef",
                  {bus.psel, bus.penable, bus.pwrite}, bus.paddr, bus.pwdata);
      end
      @(negedge pclk);
      vectors++;
      if ({bus.psel, bus.penable} !== 2'b11 || bus.paddr !== 32'h4 || bus.pwdata !== 32'hDEADBEEF) begin
         miscompares++;
         $display("FAIL wr_access: psel/pen=%b paddr=%h pwdata=%h required 11 4 deadbeef",
                  {bus.psel, bus.penable}, bus.paddr, bus.pwdata);
      end
      wait_rsp(2, lat);
      vectors++;
      if (lat !== 3) begin
         miscompares++;
         $display("FAIL wr_latency: rsp at N+%0d required N+3", lat);
      end
      e = pop_exp();
      vectors++;
      if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL wr_rsp: err=%b rdata=%h required %b %h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
      end
      vectors++;
      if (bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0 || bus.paddr !== 32'h4) begin
         miscompares++;
         $display("FAIL wr_idle: cmd_ready=%b psel=%b paddr=%h required 1 0 4", bus.cmd_ready, bus.psel, bus.paddr);
      end
      @(negedge pclk);
   endtask

   task automatic test_read_wait();
      rsp_t e;
      int   lat;
      int   pen;
      bit   stable;
      send_cmd(1'b0, 32'h8, 32'h0, 3, 1'b0, 32'h12345678, 1'b0);
      pen    = 0;
      stable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge pclk);
         if (bus.penable === 1'b1) pen++;
         if (bus.psel !== 1'b1 || bus.paddr !== 32'h8 || bus.pwrite !== 1'b0) stable = 1'b0;
      end
      vectors++;
      if (pen !== 4 || !stable) begin
         miscompares++;
         $display("FAIL rd_access: penable cycles=%0d stable=%0d required 4 1", pen, stable);
      end
      wait_rsp(5, lat);
      vectors++;
      if (lat !== 6) begin
         miscompares++;
         $display("FAIL rd_latency: rsp at N+%0d required N+6", lat);
      end
      e = pop_exp();
      vectors++;
      if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL rd_rsp: err=%b rdata=%h required %b %h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
      end
      @(negedge pclk);
   endtask

   task automatic test_slave_error();
      rsp_t e;
      int   lat;
      send_cmd(1'b0, 32'h10, 32'h0, 0, 1'b1, 32'hFFFF0000, 1'b0);
      wait_rsp(1, lat);
      vectors++;
      if (lat !== 3) begin
         miscompares++;
         $display("FAIL err_latency: rsp at N+%0d required N+3", lat);
      end
      e = pop_exp();
      vectors++;
      if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL err_rsp: err=%b rdata=%h required %b %h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
      end
      @(negedge pclk);
   endtask

   task automatic test_timeout();
      rsp_t e;
      int   acc;
      send_cmd(1'b0, 32'h20, 32'h0, -1, 1'b0, 32'h55, 1'b0);
      @(negedge pclk);
      acc = 0;
      while (bus.penable === 1'b1 && acc < 20) begin
         acc++;
         @(negedge pclk);
      end
      vectors++;
      if (acc !== 4) begin
         miscompares++;
         $display("FAIL to_access: ACCESS cycles=%0d required 4", acc);
      end
      vectors++;
      if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0011) begin
         miscompares++;
         $display("FAIL to_abort: psel/pen/rsp_valid/cmd_ready=%b required 0011",
                  {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
      end
      e = pop_exp();
      vectors++;
      if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL to_rsp: err=%b rdata=%h required %b %h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
      end
      @(negedge pclk);
   endtask

   task automatic test_back_to_back();
      rsp_t e;
      rsp_t e2;
      int   lat;
      send_cmd(1'b1, 32'h1, 32'h11, 0, 1'b0, 32'hCAFE0002, 1'b1);
      @(negedge pclk);
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h2;
      vectors++;
      if (bus.cmd_ready !== 1'b0 || bus.penable !== 1'b1) begin
         miscompares++;
         $display("FAIL b2b_busy: cmd_ready=%b penable=%b required 0 1", bus.cmd_ready, bus.penable);
      end
      @(negedge pclk);
      vectors++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.psel} !== 3'b110 || bus.paddr !== 32'h1) begin
         miscompares++;
         $display("FAIL b2b_gap: rsp_valid/cmd_ready/psel=%b paddr=%h required 110 1",
                  {bus.rsp_valid, bus.cmd_ready, bus.psel}, bus.paddr);
      end
      e = pop_exp();
      vectors++;
      if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL b2b_rsp1: err=%b rdata=%h required %b %h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
      end
      e2.err   = 1'b0;
      e2.rdata = 32'hCAFE0002;
      exp_q.push_back(e2);
      @(negedge pclk);
      bus.cmd_valid = 1'b0;
      vectors++;
      if (bus.psel !== 1'b1 || bus.penable !== 1'b0 || bus.paddr !== 32'h2 || bus.pwrite !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_setup2: psel=%b pen=%b paddr=%h pwrite=%b required 1 0 2 0",
                  bus.psel, bus.penable, bus.paddr, bus.pwrite);
      end
      wait_rsp(1, lat);
      vectors++;
      if (lat !== 3) begin
         miscompares++;
         $display("FAIL b2b_latency2: rsp at N+%0d required N+3", lat);
      end
      e = pop_exp();
      vectors++;
      if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL b2b_rsp2: err=%b rdata=%h required %b %h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
      end
      @(negedge pclk);
   endtask

   task automatic test_async_reset();
      rsp_t e;
      int   lat;
      int   rsp_before;
      rsp_before = rsp_count;
      send_cmd(1'b0, 32'h30, 32'h0, 3, 1'b0, 32'h77, 1'b0);
      @(negedge pclk);
      #2 presetn = 1'b0;
      #1;
      vectors++;
      if ({bus.psel, bus.penable, bus.rsp_valid} !== 3'b000) begin
         miscompares++;
         $display("FAIL ar_drop: psel/pen/rsp_valid=%b required 000", {bus.psel, bus.penable, bus.rsp_valid});
      end
      exp_q.delete();
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      repeat (6) @(negedge pclk);
      vectors++;
      if (rsp_count !== rsp_before || bus.cmd_ready !== 1'b1 || bus.psel !== 1'b0) begin
         miscompares++;
         $display("FAIL ar_stale: rsp pulses=%0d cmd_ready=%b psel=%b required %0d 1 0",
                  rsp_count, bus.cmd_ready, bus.psel, rsp_before);
      end
      send_cmd(1'b0, 32'h40, 32'h0, 0, 1'b0, 32'h0BADF00D, 1'b0);
      wait_rsp(1, lat);
      vectors++;
      if (lat !== 3) begin
         miscompares++;
         $display("FAIL ar_latency: rsp at N+%0d required N+3", lat);
      end
      e = pop_exp();
      vectors++;
      if (bus.rsp_err !== e.err || bus.rsp_rdata !== e.rdata) begin
         miscompares++;
         $display("FAIL ar_rsp: err=%b rdata=%h required %b %h", bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
      end
      @(negedge pclk);
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait();
      test_slave_error();
      test_timeout();
      test_back_to_back();
      test_async_reset();
      vectors++;
      if (exp_q.size() !== 0) begin
         miscompares++;
         $display("FAIL leftover: %0d expected responses never seen, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator. Converts a simple single-outstanding command/response interface into APB3 SETUP/ACCESS transfers toward APB completers such as the on-chip register/memory slaves.
- Sits on the APB side of the AHB-to-APB path. The bridge front-end issues commands; this block drives psel/penable/pwrite/paddr/pwdata and returns read data and error status.
- Provides a wait-state timeout so a hung completer cannot stall the bridge.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr/paddr
- DATA_WIDTH, 32, width of write/read data paths
- TIMEOUT, 16, max ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
- pclk  input  1  APB clock; all logic on rising edge
- presetn  input  1  reset, asynchronous assert, active-low
- cmd_valid  input  1  command request
- cmd_ready  output  1  block can accept a command (IDLE only)
- cmd_write  input  1  1 = write, 0 = read
- cmd_addr  input  ADDR_WIDTH  transfer address
- cmd_wdata  input  DATA_WIDTH  write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and for errors
- rsp_err  output  1  pslverr sampled high, or timeout; valid with rsp_valid
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- prdata  input  DATA_WIDTH  completer read data
- pready  input  1  completer ready
- pslverr  input  1  completer error

Behaviour:
- Reset (presetn low, asynchronous):
  - state = IDLE
  - psel, penable, pwrite, rsp_valid, rsp_err = 0
  - paddr, pwdata, rsp_rdata = 0
  - cmd_ready = 1 once reset is released
  - wait counter = 0
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered, except cmd_ready = (state == IDLE).
- IDLE:
  - psel = 0, penable = 0.
  - On cmd_valid && cmd_ready, latch cmd_write/cmd_addr/cmd_wdata into pwrite/paddr/pwdata and go to SETUP.
- SETUP (exactly 1 cycle): psel = 1, penable = 0; go to ACCESS.
- ACCESS:
  - psel = 1, penable = 1.
  - pready and pslverr are sampled at each rising edge.
  - If pready = 1: go to IDLE; next cycle rsp_valid = 1, rsp_err = pslverr, rsp_rdata = (!pwrite && !pslverr) ? prdata : 0.
  - If pready = 0: stay in ACCESS and increment the wait counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with pready still 0: abort, go to IDLE, and next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
  - The counter clears on leaving ACCESS.
- pwrite, paddr and pwdata are held stable from SETUP through the last ACCESS cycle. They also retain their value in IDLE (no toggling between transfers).
- Latency:
  - Handshake at edge N; SETUP cycle N+1; ACCESS cycle N+2.
  - With zero wait states, rsp_valid is high in cycle N+3 and cmd_ready is high in that same cycle.
  - Minimum 3 cycles per transfer; with W wait states, rsp_valid falls in cycle N+3+W.
- rsp_valid is a single-cycle pulse with no backpressure. The consumer must sample it.
- One outstanding transfer at a time. cmd_valid while not IDLE is ignored (cmd_ready = 0).
- A command may be accepted in the same cycle rsp_valid is high (back-to-back).
- pslverr is only meaningful when pready = 1 in ACCESS; it is ignored at all other times.
- Reset asserted mid-transfer: psel/penable drop immediately and no rsp_valid is generated for the aborted transfer.
- Counter width is sufficient for TIMEOUT without overflow; wrap-around is not possible.

Test Plan:
- Write, 0 wait: cmd(write, addr 0x4, wdata 0xDEADBEEF), pready = 1 → psel rises at N+1, penable at N+2, paddr = 0x4, pwdata = 0xDEADBEEF stable; rsp_valid at N+3 with rsp_err = 0, rsp_rdata = 0.
- Read, 3 wait states: cmd(read, addr 0x8), pready low for 3 ACCESS cycles, prdata = 0x12345678 → penable held 4 cycles, addr stable; rsp_valid at N+6 with rsp_rdata = 0x12345678, rsp_err = 0.
- Slave error: read with pready = 1, pslverr = 1, prdata = 0xFFFF0000 → rsp_err = 1, rsp_rdata = 0.
- Timeout: TIMEOUT = 4, pready held 0 → ACCESS lasts 4 cycles then psel/penable drop; rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; cmd_ready returns to 1.
- Back-to-back and ignore: cmd_valid held high with write 0x1 then read 0x2 → second command accepted on the rsp_valid cycle of the first, with exactly one IDLE cycle between psel pulses. A new cmd_valid presented during ACCESS is not accepted.
- Async reset: assert presetn low mid-ACCESS (between clock edges) → psel/penable/rsp_valid go to 0 immediately; after release, state is IDLE and no stale rsp_valid pulse appears.
